// File: rtl/rv_decode_execute_pkg.sv
// rv_pkg: shared constants and types for the RV32I decode/execute slice.
// Contents: opcode and funct7 constants, instruction-type and ALU-op enums,
// and the opcode classifier used by decode.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef enum logic [3:0] {
        TYPE_NOP     = 4'd0,
        TYPE_R       = 4'd1,
        TYPE_I_ALU   = 4'd2,
        TYPE_INVALID = 4'd15
    } inst_type_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    // The all-zero word is checked before the opcode so it is a NOP
    // rather than an invalid opcode 0000000.
    function automatic inst_type_t classify(input logic [31:0] instr);
        inst_type_t t;
        if (instr == '0)
            t = TYPE_NOP;
        else if (instr[6:0] == OP_R)
            t = TYPE_R;
        else if (instr[6:0] == OP_I_ALU)
            t = TYPE_I_ALU;
        else
            t = TYPE_INVALID;
        return t;
    endfunction

endpackage

// File: rtl/rv_decode_execute_if.sv
// rv_decode_execute_if: bus between fetch/writeback and the decode/execute core.
// Signals:
//   instruction       fetch -> core, 32-bit instruction word
//   wb_write_enable   writeback -> core, register-file write strobe
//   wb_write_addr     writeback -> core, write address
//   wb_write_data     writeback -> core, write data
//   data_out          core -> writeback, execute result
//   reg_dest_out      core -> writeback, destination register
//   write_enable_out  core -> writeback, result must be written
//   stall             core -> fetch, hazard request (always 0)
// Modports: master = environment side, slave = core side.
interface rv_decode_execute_if;

    logic [31:0] instruction;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic [31:0] data_out;
    logic [4:0]  reg_dest_out;
    logic        write_enable_out;
    logic        stall;

    modport master (
        output instruction, wb_write_enable, wb_write_addr, wb_write_data,
        input  data_out, reg_dest_out, write_enable_out, stall
    );

    modport slave (
        input  instruction, wb_write_enable, wb_write_addr, wb_write_data,
        output data_out, reg_dest_out, write_enable_out, stall
    );

endinterface

// File: rtl/rv_decode_execute_reg_file.sv
// reg_file: 32 x 32-bit integer register file, x0 hardwired to zero.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high clear
//   rs1_addr/rs1_data       read port 1 (combinational, write-through)
//   rs2_addr/rs2_data       read port 2 (combinational, write-through)
//   write_enable/addr/data  single write port, applied at the rising edge
module reg_file (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        write_enable,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data
);

    logic [31:0] regs [32];
    logic        bypass_valid;

    // Reset wins over a simultaneous write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (write_enable && write_addr != '0) begin
            regs[write_addr] <= write_data;
        end
    end

    assign bypass_valid = write_enable && (write_addr != '0);

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0)
            rs1_data = (bypass_valid && write_addr == rs1_addr) ? write_data : regs[rs1_addr];
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0)
            rs2_data = (bypass_valid && write_addr == rs2_addr) ? write_data : regs[rs2_addr];
    end

endmodule

// File: rtl/rv_decode_execute.sv
// rv_decode_execute: RV32I integer decode/execute core, two-stage pipeline.
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high; clears register file and D/X registers
//   bus     rv_decode_execute_if.slave (instruction in, wb write port in,
//           data_out/reg_dest_out/write_enable_out/stall out)
// Stage D registers decoded fields and operands; stage X registers the
// ALU result. Result appears two edges after the instruction is sampled.
module rv_decode_execute
    import rv_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    rv_decode_execute_if.slave bus
);

    logic [31:0] instr;
    inst_type_t  dec_type;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;

    assign instr    = bus.instruction;
    assign dec_type = classify(instr);

    reg_file u_reg_file (
        .clock        (clock),
        .reset        (reset),
        .rs1_addr     (instr[19:15]),
        .rs1_data     (rf_rs1_data),
        .rs2_addr     (instr[24:20]),
        .rs2_data     (rf_rs2_data),
        .write_enable (bus.wb_write_enable),
        .write_addr   (bus.wb_write_addr),
        .write_data   (bus.wb_write_data)
    );

    // Stage D
    logic [31:0] d_rs1;
    logic [31:0] d_rs2;
    logic [31:0] d_imm;
    logic [4:0]  d_rd;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    inst_type_t  d_type;
    logic        d_is_write;
    logic        d_is_imm;

    always_ff @(posedge clock) begin
        if (reset) begin
            d_rs1      <= '0;
            d_rs2      <= '0;
            d_imm      <= '0;
            d_rd       <= '0;
            d_funct3   <= '0;
            d_funct7   <= '0;
            d_type     <= TYPE_NOP;
            d_is_write <= 1'b0;
            d_is_imm   <= 1'b0;
        end else begin
            d_rs1      <= rf_rs1_data;
            d_rs2      <= rf_rs2_data;
            d_imm      <= {{20{instr[31]}}, instr[31:20]};
            d_rd       <= instr[11:7];
            d_funct3   <= instr[14:12];
            d_funct7   <= instr[31:25];
            d_type     <= dec_type;
            d_is_write <= (dec_type == TYPE_R) || (dec_type == TYPE_I_ALU);
            d_is_imm   <= (dec_type == TYPE_I_ALU);
        end
    end

    // Execute (combinational from D registers)
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        legal;
    alu_op_t     alu_op;
    logic [31:0] alu_result;

    assign op_b  = d_is_imm ? d_imm : d_rs2;
    assign shamt = op_b[4:0];

    // For I-type, funct7 is imm[11:5]; it only constrains the shift forms.
    always_comb begin
        legal = 1'b1;
        if (d_type == TYPE_R) begin
            if (!(d_funct7 == F7_BASE ||
                  (d_funct7 == F7_ALT && (d_funct3 == 3'b000 || d_funct3 == 3'b101))))
                legal = 1'b0;
        end else if (d_type == TYPE_I_ALU) begin
            if (d_funct3 == 3'b001 && d_funct7 != F7_BASE)
                legal = 1'b0;
            if (d_funct3 == 3'b101 && d_funct7 != F7_BASE && d_funct7 != F7_ALT)
                legal = 1'b0;
        end
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (d_funct3)
            3'b000:  alu_op = (d_type == TYPE_R && d_funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = (d_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = d_rs1 + op_b;
            ALU_SUB:  alu_result = d_rs1 - op_b;
            ALU_SLL:  alu_result = d_rs1 << shamt;
            ALU_SLT:  alu_result = {31'b0, $signed(d_rs1) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'b0, d_rs1 < op_b};
            ALU_XOR:  alu_result = d_rs1 ^ op_b;
            ALU_SRL:  alu_result = d_rs1 >> shamt;
            ALU_SRA:  alu_result = $signed(d_rs1) >>> shamt;
            ALU_OR:   alu_result = d_rs1 | op_b;
            ALU_AND:  alu_result = d_rs1 & op_b;
            default:  alu_result = '0;
        endcase
    end

    // Stage X
    logic [31:0] x_data;
    logic [4:0]  x_rd;
    logic        x_we;
    logic        do_write;

    assign do_write = d_is_write && legal;

    always_ff @(posedge clock) begin
        if (reset) begin
            x_data <= '0;
            x_rd   <= '0;
            x_we   <= 1'b0;
        end else begin
            x_data <= do_write ? alu_result : '0;
            x_rd   <= d_rd;
            x_we   <= do_write && (d_rd != '0);
        end
    end

    assign bus.data_out         = x_data;
    assign bus.reg_dest_out     = x_rd;
    assign bus.write_enable_out = x_we;
    assign bus.stall            = 1'b0;

endmodule

// File: tb/tb_rv_decode_execute.sv
// tb_rv_decode_execute: randomized self-checking bench for rv_decode_execute.
// A behavioural model (architectural register array plus a two-deep result
// pipe) predicts the outputs every cycle; directed cases pin literal values.
module tb_rv_decode_execute;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_decode_execute_if bus ();

    rv_decode_execute dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    logic [31:0] mem [32];
    res_t        exp_d;
    res_t        exp_x;

    // Architectural read as seen at the sampling edge (write-through).
    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        if (bus.wb_write_enable && bus.wb_write_addr == a)
            return bus.wb_write_data;
        return mem[a];
    endfunction

    function automatic res_t model_exec(input logic [31:0] ins,
                                        input logic [31:0] a,
                                        input logic [31:0] rs2v);
        res_t        r;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] b;
        logic [31:0] v;
        bit          is_r;
        bit          is_i;
        bit          ok;
        opc  = ins[6:0];
        f7   = ins[31:25];
        f3   = ins[14:12];
        imm  = {{20{ins[31]}}, ins[31:20]};
        r.rd = ins[11:7];
        r.data = 32'd0;
        r.we = 1'b0;
        is_r = (opc == 7'h33);
        is_i = (opc == 7'h13);
        if (!is_r && !is_i)
            return r;
        b  = is_i ? imm : rs2v;
        ok = 1'b1;
        v  = 32'd0;
        case (f3)
            3'd0: begin
                if (is_r && f7 == 7'h20) v = a - b;
                else begin
                    v = a + b;
                    if (is_r && f7 != 7'h00) ok = 1'b0;
                end
            end
            3'd1: begin v = a << b[4:0]; if (f7 != 7'h00) ok = 1'b0; end
            3'd2: begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; if (is_r && f7 != 7'h00) ok = 1'b0; end
            3'd3: begin v = (a < b) ? 32'd1 : 32'd0; if (is_r && f7 != 7'h00) ok = 1'b0; end
            3'd4: begin v = a ^ b; if (is_r && f7 != 7'h00) ok = 1'b0; end
            3'd5: begin
                if (f7 == 7'h20) v = $signed(a) >>> b[4:0];
                else v = a >> b[4:0];
                if (f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
            end
            3'd6: begin v = a | b; if (is_r && f7 != 7'h00) ok = 1'b0; end
            default: begin v = a & b; if (is_r && f7 != 7'h00) ok = 1'b0; end
        endcase
        r.data = ok ? v : 32'd0;
        r.we   = ok && (r.rd != 5'd0);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= 32'd0;
            exp_d <= '0;
            exp_x <= '0;
        end else begin
            exp_x <= exp_d;
            exp_d <= model_exec(bus.instruction,
                                rd_model(bus.instruction[19:15]),
                                rd_model(bus.instruction[24:20]));
            if (bus.wb_write_enable && bus.wb_write_addr != 5'd0)
                mem[bus.wb_write_addr] <= bus.wb_write_data;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if ({bus.data_out, bus.reg_dest_out, bus.write_enable_out, bus.stall} !==
                    {exp_x.data, exp_x.rd, exp_x.we, 1'b0}) begin
                    n_bad++;
                    $display("FAIL pipe t=%0t: got data=%h rd=%0d we=%b stall=%b, need data=%h rd=%0d we=%b stall=0",
                             $time, bus.data_out, bus.reg_dest_out, bus.write_enable_out,
                             bus.stall, exp_x.data, exp_x.rd, exp_x.we);
                end
            end
        end
    end

    task automatic cyc(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic r);
        @(negedge clk);
        bus.instruction     = ins;
        bus.wb_write_enable = we;
        bus.wb_write_addr   = wa;
        bus.wb_write_data   = wd;
        rst                 = r;
    endtask

    task automatic issue(input logic [31:0] ins);
        cyc(ins, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic pin(input string nm, input logic [31:0] ed, input logic [4:0] erd,
                       input logic ew, input bit chk_data);
        n_cmp++;
        if ((chk_data && bus.data_out !== ed) || bus.reg_dest_out !== erd ||
            bus.write_enable_out !== ew) begin
            n_bad++;
            $display("FAIL %s: got data=%h rd=%0d we=%b, need data=%h rd=%0d we=%b",
                     nm, bus.data_out, bus.reg_dest_out, bus.write_enable_out, ed, erd, ew);
        end
    endtask

    initial begin
        bus.instruction     = '0;
        bus.wb_write_enable = 1'b0;
        bus.wb_write_addr   = '0;
        bus.wb_write_data   = '0;
        rst                 = 1'b1;

        cyc(32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        issue(32'd0);
        pin("reset_state", 32'd0, 5'd0, 1'b0, 1'b1);
        chk_en = 1'b1;

        cyc(32'd0, 1'b1, 5'd1, 32'd5, 1'b0);
        cyc(32'd0, 1'b1, 5'd2, 32'd3, 1'b0);
        issue(32'h002081B3);                       // ADD x3,x1,x2
        issue(32'd0);
        issue(32'd0);
        pin("add", 32'd8, 5'd3, 1'b1, 1'b1);

        issue(32'h40208233);                       // SUB x4,x1,x2
        issue(32'hFFF08293);                       // ADDI x5,x1,-1
        issue(32'd0);
        pin("sub", 32'd2, 5'd4, 1'b1, 1'b1);
        issue(32'd0);
        pin("addi_b2b", 32'd4, 5'd5, 1'b1, 1'b1);

        cyc(32'd0, 1'b1, 5'd7, 32'h80000000, 1'b0);
        issue(32'h4043D313);                       // SRAI x6,x7,4
        issue(32'd0);
        issue(32'd0);
        pin("srai", 32'hF8000000, 5'd6, 1'b1, 1'b1);

        cyc(32'd0, 1'b1, 5'd0, 32'h0000FFFF, 1'b0);
        issue(32'h000001B3);                       // ADD x3,x0,x0
        issue(32'd0);
        issue(32'd0);
        pin("x0_write", 32'd0, 5'd3, 1'b1, 1'b1);

        issue(32'h00208033);                       // ADD x0,x1,x2
        issue(32'd0);
        issue(32'd0);
        pin("rd_zero", 32'd0, 5'd0, 1'b0, 1'b0);

        issue(32'h0000007F);
        issue(32'd0);
        issue(32'd0);
        pin("invalid_op", 32'd0, 5'd0, 1'b0, 1'b1);

        cyc(32'h002081B3, 1'b1, 5'd1, 32'd10, 1'b0);   // ADD x3,x1,x2 with x1 <- 10
        issue(32'd0);
        issue(32'd0);
        pin("bypass", 32'd13, 5'd3, 1'b1, 1'b1);

        issue(32'h002081B3);
        cyc(32'd0, 1'b1, 5'd5, 32'd123, 1'b1);     // reset wins over this write
        issue(32'd0);
        pin("reset_mid", 32'd0, 5'd0, 1'b0, 1'b1);
        issue(32'h00028433);                       // ADD x8,x5,x0
        issue(32'h002081B3);                       // ADD x3,x1,x2
        issue(32'd0);
        pin("post_rst_x5", 32'd0, 5'd8, 1'b1, 1'b1);
        issue(32'd0);
        pin("post_rst_x1x2", 32'd0, 5'd3, 1'b1, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic [6:0]  f7;
            logic [6:0]  opc;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            opc = (sel < 6) ? 7'h33 : 7'h13;
            ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
            if (sel == 0)
                ins = 32'd0;
            else if (sel == 1)
                ins = $urandom;
            cyc(ins, 1'($urandom), 5'($urandom),
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                ($urandom_range(0, 149) == 0));
        end

        issue(32'd0);
        issue(32'd0);
        issue(32'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
